// File: rtl/posit_unpack_pipe.sv
// posit_unpack_pipe: three-stage streaming posit decoder (classify, regime, fields)
// with valid/ready backpressure on both sides.
module posit_unpack_pipe #(
    parameter int NBITS = 32,
    parameter int ES    = 3,
    parameter int SBITS = 9,
    parameter int FBITS = NBITS - 3 - ES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NBITS-1:0] in_posit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic             out_zero,
    output logic             out_inf,
    output logic [SBITS-1:0] out_scale,
    output logic [FBITS-1:0] out_frac
);
    localparam int BW = NBITS - 1;
    localparam int MW = $clog2(NBITS);
    localparam int KW = SBITS - ES;
    localparam int RW = ES + FBITS;

    logic             ld1, ld2, ld3;
    logic             v1_q, sign1_q, zero1_q, inf1_q;
    logic [BW-1:0]    body1_q;
    logic             v2_q, sign2_q, zero2_q, inf2_q;
    logic [KW-1:0]    k2_q;
    logic [RW-1:0]    rem2_q;
    logic             v3_q, sign3_q, zero3_q, inf3_q;
    logic [SBITS-1:0] scale3_q;
    logic [FBITS-1:0] frac3_q;

    logic [BW-1:0]    body_d, x_d;
    logic [MW-1:0]    m_d;
    logic [KW-1:0]    k_d;
    logic [RW-1:0]    rem_d;

    assign ld3      = !v3_q | out_ready;
    assign ld2      = !v2_q | ld3;
    assign ld1      = !v1_q | ld2;
    assign in_ready = ld1;

    assign body_d = in_posit[NBITS-1] ? BW'(-in_posit) : in_posit[NBITS-2:0];

    // Regime length m is the leading-zero count of body XOR its top bit.
    // Shifting body[BW-3:0] by m-1 equals shifting body by m+1 and dropping two LSBs.
    always_comb begin
        x_d = body1_q ^ {BW{body1_q[BW-1]}};
        m_d = MW'(BW);
        for (int i = 0; i < BW; i++) if (x_d[i]) m_d = MW'(BW - 1 - i);
        rem_d = (zero1_q | inf1_q) ? '0 : body1_q[BW-3:0] << (m_d - 1'b1);
        k_d   = (zero1_q | inf1_q) ? '0 : body1_q[BW-1] ? KW'(m_d) - 1'b1 : '0 - KW'(m_d);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v1_q     <= 1'b0;
            sign1_q  <= 1'b0;
            zero1_q  <= 1'b0;
            inf1_q   <= 1'b0;
            body1_q  <= '0;
            v2_q     <= 1'b0;
            sign2_q  <= 1'b0;
            zero2_q  <= 1'b0;
            inf2_q   <= 1'b0;
            k2_q     <= '0;
            rem2_q   <= '0;
            v3_q     <= 1'b0;
            sign3_q  <= 1'b0;
            zero3_q  <= 1'b0;
            inf3_q   <= 1'b0;
            scale3_q <= '0;
            frac3_q  <= '0;
        end else begin
            if (ld1) begin
                v1_q <= in_valid;
                if (in_valid) begin
                    sign1_q <= in_posit[NBITS-1];
                    zero1_q <= in_posit == '0;
                    inf1_q  <= in_posit == {1'b1, {BW{1'b0}}};
                    body1_q <= body_d;
                end
            end
            if (ld2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    sign2_q <= sign1_q;
                    zero2_q <= zero1_q;
                    inf2_q  <= inf1_q;
                    k2_q    <= k_d;
                    rem2_q  <= rem_d;
                end
            end
            if (ld3) begin
                v3_q <= v2_q;
                if (v2_q) begin
                    sign3_q  <= sign2_q;
                    zero3_q  <= zero2_q;
                    inf3_q   <= inf2_q;
                    scale3_q <= {k2_q, rem2_q[RW-1 -: ES]};
                    frac3_q  <= rem2_q[FBITS-1:0];
                end
            end
        end
    end

    assign out_valid = v3_q;
    assign out_sign  = sign3_q;
    assign out_zero  = zero3_q;
    assign out_inf   = inf3_q;
    assign out_scale = scale3_q;
    assign out_frac  = frac3_q;
endmodule

// File: tb/tb_posit_unpack_pipe.sv
// tb_posit_unpack_pipe: random and directed stimulus checked against a bit-walking
// posit decode model and an in-order scoreboard.
module tb_posit_unpack_pipe;
    logic        clk = 1'b0;
    logic        reset_n, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_posit;
    logic        out_sign, out_zero, out_inf;
    logic [8:0]  out_scale;
    logic [25:0] out_frac;
    logic [37:0] got, held;
    logic [37:0] exp_q[$];
    logic        hold_v = 1'b0;
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    posit_unpack_pipe dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_posit(in_posit), .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_zero(out_zero), .out_inf(out_inf),
        .out_scale(out_scale), .out_frac(out_frac)
    );

    assign got = {out_sign, out_zero, out_inf, out_scale, out_frac};

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", n, a, e);
        end
    endtask

    // Walks the posit bit by bit: sign, regime run, terminator, exponent, fraction.
    function automatic logic [37:0] ref_decode(input logic [31:0] p);
        logic [31:0] a;
        logic [25:0] f;
        int pos, m, k, e, sc;
        if (p == 32'h0) return {3'b010, 35'd0};
        if (p == 32'h8000_0000) return {3'b101, 35'd0};
        a = p[31] ? 32'd0 - p : p;
        pos = 30;
        m = 0;
        while (pos >= 0 && a[pos[4:0]] == a[30]) begin
            m++;
            pos--;
        end
        k = a[30] ? m - 1 : -m;
        pos--;
        e = 0;
        for (int i = 0; i < 3; i++) begin
            e = e * 2 + ((pos >= 0) ? int'(a[pos[4:0]]) : 0);
            pos--;
        end
        f = '0;
        for (int i = 25; i >= 0; i--) begin
            f[i] = (pos >= 0) ? a[pos[4:0]] : 1'b0;
            pos--;
        end
        sc = k * 8 + e;
        return {p[31], 2'b00, sc[8:0], f};
    endfunction

    function automatic logic [31:0] rnd_posit();
        logic [31:0] w;
        w = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) w = 32'd0 - w;
        if ($urandom_range(0, 15) == 0) w = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h0;
        return w;
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) chk("hold", {out_valid, got}, {1'b1, held});
            hold_v = out_valid && !out_ready;
            held = got;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_out", {1'b1, got}, 39'd0);
                else chk("data", got, exp_q.pop_front());
            end
            if (in_valid && in_ready) exp_q.push_back(ref_decode(in_posit));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, output int tries);
        logic acc;
        in_valid = 1'b1;
        in_posit = w;
        tries = 0;
        acc = 1'b0;
        while (!acc && tries < 100) begin
            acc = in_ready;
            tries++;
            tick();
        end
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 50) begin
            tick();
            t++;
        end
        chk("drain", {32'(exp_q.size()), 31'd0, out_valid}, 64'd0);
    endtask

    initial begin
        logic [31:0] dir[8];
        int tries, cnt;
        logic acc;
        dir = '{32'h4000_0000, 32'h4800_0000, 32'hC000_0000, 32'h0000_0001,
                32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0000, 32'h4040_0000};
        reset_n = 1'b0;
        in_valid = 1'b0;
        in_posit = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_data", got, 0);
        reset_n = 1'b1;
        tick();

        chk("model_one", ref_decode(32'h4000_0000), {3'b000, 9'd0, 26'd0});
        chk("model_four", ref_decode(32'h4800_0000), {3'b000, 9'd2, 26'd0});
        chk("model_neg_one", ref_decode(32'hC000_0000), {3'b100, 9'd0, 26'd0});
        chk("model_minpos", ref_decode(32'h0000_0001), {3'b000, 9'h110, 26'd0});
        chk("model_maxpos", ref_decode(32'h7FFF_FFFF), {3'b000, 9'd240, 26'd0});
        chk("model_zero", ref_decode(32'h0000_0000), {3'b010, 9'd0, 26'd0});
        chk("model_nar", ref_decode(32'h8000_0000), {3'b101, 9'd0, 26'd0});
        chk("model_1p5", ref_decode(32'h4200_0000), {3'b000, 9'd0, 26'h200_0000});
        chk("model_4040", ref_decode(32'h4040_0000), {3'b000, 9'd0, 26'h040_0000});

        send(32'h4000_0000, tries);
        chk("lat_e1", out_valid, 0);
        tick();
        chk("lat_e2", out_valid, 0);
        tick();
        chk("lat_e3", {out_valid, got}, {1'b1, 38'd0});
        drain();

        foreach (dir[i]) send(dir[i], tries);
        send(32'h4200_0000, tries);
        drain();

        for (int i = 0; i < 16; i++) begin
            send(rnd_posit(), tries);
            chk("stream_tput", tries, 1);
        end
        chk("stream_depth", exp_q.size() <= 3, 1);
        drain();

        out_ready = 1'b0;
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_posit = rnd_posit();
            acc = in_ready;
            tick();
            if (acc) cnt++;
        end
        chk("bp_accepts", cnt, 3);
        chk("bp_in_ready", in_ready, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        for (int c = 0; c < 400; c++) begin
            in_valid = $urandom_range(0, 1);
            in_posit = rnd_posit();
            out_ready = $urandom_range(0, 3) != 0;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        send(32'h4800_0000, tries);
        send(32'h0000_0001, tries);
        reset_n = 1'b0;
        tick();
        chk("rst_flush_valid", out_valid, 0);
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("rst_no_emit", out_valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
